// File: rtl/dl_bus_pkg.sv
// Shared types and constants for the DataLatch bus-cycle sequencer.
// Optional wait-state support is built when DL_BUS_WAIT_EN is defined.
package dl_bus_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4
    } state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } op_t;

    typedef struct packed {
        logic mreq_n;
        logic rd_n;
        logic wr_n;
        logic db_oe;
        logic dl_control1;
        logic dl_control2;
    } strobe_t;

    localparam strobe_t STROBE_IDLE = '{
        mreq_n:      1'b1,
        rd_n:        1'b1,
        wr_n:        1'b1,
        db_oe:       1'b0,
        dl_control1: 1'b1,
        dl_control2: 1'b0
    };

endpackage

// File: rtl/dl_bus_seq_fsm.sv
// T-state sequencer: state/op registers, accept and next-state logic.
// With DL_BUS_WAIT_EN defined, wait_n stretches T3.
module dl_tstate_fsm
    import dl_bus_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
`ifdef DL_BUS_WAIT_EN
    input  logic   wait_n,
`endif
    input  logic   req_rd,
    input  logic   req_wr,
    output state_t state,
    output op_t    op,
    output logic   accept,
    output logic   leave_t3
);

    state_t state_d;
    op_t    op_d;
    logic   t3_done;

`ifdef DL_BUS_WAIT_EN
    assign t3_done = wait_n;
`else
    assign t3_done = 1'b1;
`endif

    assign leave_t3 = (state == ST_T3) && t3_done;

    always_comb begin
        accept  = ((state == ST_IDLE) || (state == ST_T4))
                  && (req_rd || req_wr);
        state_d = state;
        op_d    = op;
        unique case (state)
            ST_IDLE,
            ST_T4: begin
                if (accept) begin
                    state_d = ST_T1;
                    // read wins a simultaneous request
                    op_d    = req_rd ? OP_RD : OP_WR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_T1:   state_d = ST_T2;
            ST_T2:   state_d = ST_T3;
            ST_T3:   state_d = t3_done ? ST_T4 : ST_T3;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            op    <= OP_RD;
        end else begin
            state <= state_d;
            op    <= op_d;
        end
    end

endmodule

// File: rtl/dl_bus_seq.sv
// Bus-cycle sequencer feeding the CPU DataLatch: 4-T-state M-cycles.
// Define DL_BUS_WAIT_EN to add the wait_n input (T3 stretch).
module dl_bus_seq
    import dl_bus_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          CLK,
    input  logic          nRESET,
`ifdef DL_BUS_WAIT_EN
    input  logic          wait_n,
`endif
    input  logic          req_rd,
    input  logic          req_wr,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] res,
    input  logic [DW-1:0] bus_din,
    output logic [AW-1:0] addr_out,
    output logic          mreq_n,
    output logic          rd_n,
    output logic          wr_n,
    output logic          db_oe,
    output logic          dl_control1,
    output logic          dl_control2,
    output logic [DW-1:0] dl_q,
    output logic          rd_valid,
    output logic          busy,
    output logic          accept
);

    state_t  state;
    op_t     op;
    logic    leave_t3;
    strobe_t stb;

    dl_tstate_fsm u_fsm (
        .clk      (CLK),
        .rst_n    (nRESET),
`ifdef DL_BUS_WAIT_EN
        .wait_n   (wait_n),
`endif
        .req_rd   (req_rd),
        .req_wr   (req_wr),
        .state    (state),
        .op       (op),
        .accept   (accept),
        .leave_t3 (leave_t3)
    );

    always_comb begin
        stb = STROBE_IDLE;
        if (op == OP_RD) begin
            unique case (state)
                ST_T1, ST_T2, ST_T3: begin
                    stb.mreq_n      = 1'b0;
                    stb.rd_n        = 1'b0;
                    stb.dl_control1 = 1'b0;
                end
                default: ;
            endcase
        end else begin
            unique case (state)
                ST_T1: begin
                    stb.mreq_n      = 1'b0;
                    stb.dl_control2 = 1'b1;
                end
                ST_T2, ST_T3: begin
                    stb.mreq_n      = 1'b0;
                    stb.wr_n        = 1'b0;
                    stb.db_oe       = 1'b1;
                    stb.dl_control1 = 1'b0;
                end
                ST_T4: begin
                    stb.db_oe       = 1'b1;
                    stb.dl_control1 = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign mreq_n      = stb.mreq_n;
    assign rd_n        = stb.rd_n;
    assign wr_n        = stb.wr_n;
    assign db_oe       = stb.db_oe;
    assign dl_control1 = stb.dl_control1;
    assign dl_control2 = stb.dl_control2;
    assign rd_valid    = (state == ST_T4) && (op == OP_RD);
    assign busy        = (state != ST_IDLE);

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            addr_out <= '0;
            dl_q     <= '0;
        end else begin
            if (accept) begin
                addr_out <= req_addr;
            end
            // ALU result lands in DL at end of T1; read data at end of T3
            if ((state == ST_T1) && (op == OP_WR)) begin
                dl_q <= res;
            end else if (leave_t3 && (op == OP_RD)) begin
                dl_q <= bus_din;
            end
        end
    end

endmodule
